// File: rtl/tscap_pkg.sv
// Shared constants for the timestamp capture block: edge-select encodings,
// FIFO entry width and drop-counter width (drop counter only with TSCAP_DROP_CNT_EN).
package tscap_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  localparam int CNT_W_DEF = 32;
  localparam int ENTRY_W   = CNT_W_DEF + 1;

  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Entry is {count, rise}: one polarity bit below the timestamp.
  function automatic int entry_w(input int cnt_w);
    return cnt_w + 1;
  endfunction

endpackage

// File: rtl/tscap_fifo.sv
// Synchronous FIFO with extended pointers; head is read combinationally and
// forced to zero while empty so the outputs have defined reset values.
module tscap_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign fill  = wr_ptr - rd_ptr;
  assign full  = (fill == (AW+1)'(DEPTH));
  assign empty = (fill == '0);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/timestamp_capture.sv
// Captures {count, polarity} on qualified edges of an asynchronous event line.
// Optional drop counter output drop_cnt is enabled by defining TSCAP_DROP_CNT_EN.
module timestamp_capture
  import tscap_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CNT_W-1:0]         count,
  input  logic                     event_in,
  input  logic [1:0]               edge_sel,
  output logic [CNT_W-1:0]         ts_data,
  output logic                     ts_edge,
  output logic                     ts_valid,
  input  logic                     ts_ready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  input  logic                     ovf_clr
`ifdef TSCAP_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]    drop_cnt
`endif
);

  localparam int EW = entry_w(CNT_W);

  logic [SYNC_STAGES-1:0] evt_sync_p0;
  logic                   evt_hist_p1;
  logic                   sync_lvl;
  logic                   rise;
  logic                   fall;
  logic                   rise_en;
  logic                   fall_en;
  logic                   evt;
  logic                   drop;
  logic                   full;
  logic                   empty;
  logic [EW-1:0]          head;

  // Synchronizer chain feeding the history flop; history tracks even when disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_sync_p0 <= '0;
      evt_hist_p1 <= 1'b0;
    end else begin
      evt_sync_p0 <= {evt_sync_p0[SYNC_STAGES-2:0], event_in};
      evt_hist_p1 <= evt_sync_p0[SYNC_STAGES-1];
    end
  end

  assign sync_lvl = evt_sync_p0[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~evt_hist_p1;
  assign fall     = ~sync_lvl & evt_hist_p1;
  assign rise_en  = (edge_sel == EDGE_RISE) | (edge_sel == EDGE_BOTH);
  assign fall_en  = (edge_sel == EDGE_FALL) | (edge_sel == EDGE_BOTH);
  assign evt      = (rise & rise_en) | (fall & fall_en);

  // Only a push that finds the FIFO full with no departing head is lost.
  assign drop = evt & full & ~ts_ready;

  tscap_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (evt),
    .push_data ({count, rise}),
    .pop       (ts_ready),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .fill      (fill)
  );

  assign ts_valid = ~empty;
  assign ts_data  = head[EW-1:1];
  assign ts_edge  = head[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef TSCAP_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
    end else if (drop && drop_cnt != DROP_CNT_MAX) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_timestamp_capture.sv
// Bench for timestamp_capture: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_timestamp_capture;

  localparam int CNT_W = 32;
  localparam int DEPTH = 8;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] count = '0;
  logic        event_in = 1'b0;
  logic [1:0]  edge_sel = 2'b00;
  logic        ts_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [31:0] ts_data;
  logic        ts_edge;
  logic        ts_valid;
  logic [3:0]  fill;
  logic        overflow;
`ifdef TSCAP_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  timestamp_capture #(
    .CNT_W       (CNT_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .count    (count),
    .event_in (event_in),
    .edge_sel (edge_sel),
    .ts_data  (ts_data),
    .ts_edge  (ts_edge),
    .ts_valid (ts_valid),
    .ts_ready (ts_ready),
    .fill     (fill),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
`ifdef TSCAP_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: samp holds past event_in samples, newest first.
  logic [32:0] mq[$];
  bit          samp[$];
  bit          m_ovf;
  int          m_drop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      samp.delete();
      for (int i = 0; i <= SYNC; i++) samp.push_back(1'b0);
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      bit s, h, is_rise, ev, pop, drop;
      s       = samp[SYNC-1];
      h       = samp[SYNC];
      is_rise = s && !h;
      ev      = (is_rise && edge_sel[0]) || (!s && h && edge_sel[1]);
      pop     = (mq.size() > 0) && ts_ready;
      drop    = ev && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (ev && !drop) mq.push_back({count, is_rise});
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (drop) m_drop = ovf_clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
      else if (ovf_clr) m_drop = 0;
      samp.push_front(event_in);
      void'(samp.pop_back());
    end
  end

  always @(negedge clk) begin
    logic [32:0] hd;
    hd = (mq.size() > 0) ? mq[0] : 33'd0;
    check("cmp_ts_valid", ts_valid, mq.size() != 0);
    check("cmp_fill", fill, mq.size());
    check("cmp_ts_data", ts_data, hd[32:1]);
    check("cmp_ts_edge", ts_edge, hd[0]);
    check("cmp_overflow", overflow, m_ovf);
`ifdef TSCAP_DROP_CNT_EN
    check("cmp_drop_cnt", drop_cnt, m_drop);
`endif
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      count = count + 1;
    end
  endtask

  initial begin
    logic [31:0] first_c;
    logic [31:0] c_new;

    // Reset with the line already high: exactly one rising entry after release.
    #1 rst = 1'b0;
    event_in = 1'b1;
    edge_sel = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    check("reset_fill", fill, 0);
    check("reset_valid", ts_valid, 0);
    check("reset_data", ts_data, 0);
    rst = 1'b1;
    count = 32'd1000;
    step(2);
    check("rel_no_push_yet", fill, 0);
    step(1);
    check("rel_push_fill", fill, 1);
    check("rel_push_edge", ts_edge, 1);
    check("rel_push_data", ts_data, 32'd1002);
    step(6);
    check("rel_single_entry", fill, 1);
    ts_ready = 1'b1;
    step(1);
    ts_ready = 1'b0;
    check("rel_drained", fill, 0);

    // Disabled edges still move the history: re-enable yields no false edge.
    edge_sel = 2'b00;
    event_in = 1'b0;
    step(4);
    edge_sel = 2'b11;
    step(3);
    check("reenable_no_false", fill, 0);

    // Rising at count 100, falling at 140.
    count = 32'd100;
    event_in = 1'b1;
    step(40);
    event_in = 1'b0;
    step(3);
    check("both_fill", fill, 2);
    check("both_head_data", ts_data, 32'd102);
    check("both_head_edge", ts_edge, 1);
    step(5);
    check("both_held", ts_data, 32'd102);
    ts_ready = 1'b1;
    step(1);
    ts_ready = 1'b0;
    check("both_second_data", ts_data, 32'd142);
    check("both_second_edge", ts_edge, 0);
    ts_ready = 1'b1;
    step(1);
    ts_ready = 1'b0;
    check("both_empty", ts_valid, 0);

    // Nine events into an eight-deep FIFO.
    first_c = count + 32'd2;
    for (int i = 0; i < 9; i++) begin
      event_in = ~event_in;
      step(4);
    end
    step(3);
    check("ovf_fill", fill, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_head", ts_data, first_c);
`ifdef TSCAP_DROP_CNT_EN
    check("ovf_drop_cnt", drop_cnt, 1);
`endif

    // Clear coincident with a drop: set wins.
    event_in = ~event_in;
    step(2);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("clr_drop_flag", overflow, 1);
`ifdef TSCAP_DROP_CNT_EN
    check("clr_drop_cnt", drop_cnt, 1);
`endif
    step(2);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("clr_iso_flag", overflow, 0);
`ifdef TSCAP_DROP_CNT_EN
    check("clr_iso_cnt", drop_cnt, 0);
`endif

    // Full FIFO, push coincident with pop.
    event_in = ~event_in;
    step(2);
    c_new = count;
    ts_ready = 1'b1;
    step(1);
    ts_ready = 1'b0;
    check("fullpp_fill", fill, 8);
    check("fullpp_ovf", overflow, 0);
    ts_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("fullpp_tail", ts_data, c_new);
      step(1);
    end
    ts_ready = 1'b0;
    check("fullpp_drained", fill, 0);

    // Count wrap-around.
    step(4);
    count = 32'hFFFF_FFFD;
    event_in = ~event_in;
    step(4);
    event_in = ~event_in;
    step(4);
    check("wrap_fill", fill, 2);
    check("wrap_first", ts_data, 32'hFFFF_FFFF);
    ts_ready = 1'b1;
    step(1);
    ts_ready = 1'b0;
    check("wrap_second", ts_data, 32'h0000_0003);

    // Asynchronous reset mid-stream.
    event_in = ~event_in;
    step(3);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", ts_valid, 0);
    check("midrst_fill", fill, 0);
    check("midrst_ovf", overflow, 0);
    step(2);
    rst = 1'b1;
    step(2);

    // Randomized traffic, alternating drain pressure per block.
    for (int blk = 0; blk < 15; blk++) begin
      int ready_pct;
      ready_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
      for (int cyc = 0; cyc < 200; cyc++) begin
        if ($urandom_range(0, 3) == 0) event_in = ~event_in;
        if ($urandom_range(0, 31) == 0) edge_sel = 2'($urandom_range(0, 3));
        ts_ready = ($urandom_range(0, 99) < ready_pct);
        ovf_clr  = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 63) == 0) count = $urandom;
        step(1);
      end
    end
    ts_ready = 1'b0;
    ovf_clr = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
